mux_sweep_ctrl: RTL and testbench

Upstream stimulus-and-capture stage for the team's gate-level 2:1 mux (select s, data d0/d1, output y). On a start request it walks all 8 {s,d1,d0} combinations and holds each for a programmable number of cycles. Before advancing, it samples the mux output y and builds an 8-bit truth table. It flags any mismatch against the ideal mux function (y = s ? d1 : d0).

---
 rtl/mux_sweep_pkg.sv | 21 ++
 rtl/mux_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_mux_sweep_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_sweep_pkg.sv
// Shared constants and helpers for the 2:1 mux truth-table sweep controller.
package mux_sweep_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned ST_W    = 2;

  localparam logic [7:0] EXPECTED_TRUTH = 8'hCA;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Ideal mux response for vector {s,d1,d0} = idx.
  function automatic logic exp_bit(input logic [IDX_W-1:0] idx);
    return idx[2] ? idx[1] : idx[0];
  endfunction

endpackage

// File: rtl/mux_sweep_ctrl.sv
// Walks all {s,d1,d0} vectors into a 2:1 mux, captures y per vector and flags mismatches.
module mux_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       s,
  output logic       d0,
  output logic       d1,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       err,
  output logic [2:0] first_err_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic             busy_d, done_d, err_d;
  logic [7:0]       truth_d;
  logic [2:0]       fei_d;

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      vec_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth         <= '0;
      err           <= 1'b0;
      first_err_idx <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      vec_q         <= vec_d;
      busy          <= busy_d;
      done          <= done_d;
      truth         <= truth_d;
      err           <= err_d;
      first_err_idx <= fei_d;
    end
  end

  // Next-state, hold counting and capture of y on the last held cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    truth_d = truth;
    err_d   = err;
    fei_d   = first_err_idx;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          truth_d = '0;
          err_d   = 1'b0;
          fei_d   = '0;
        end
      end

      ST_DRIVE: begin
        busy_d = 1'b1;
        vec_d  = idx_q;
        if (cnt_q == CNT_LAST) begin
          truth_d[idx_q] = y;
          if ((y != exp_bit(idx_q)) && !err) begin
            err_d = 1'b1;
            fei_d = idx_q;
          end
          cnt_d = '0;
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + IDX_W'(1);
            vec_d = idx_d;
          end else begin
            state_d = ST_DONE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            vec_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Mux drive pins come straight from the vector register.
  assign s  = vec_q[2];
  assign d1 = vec_q[1];
  assign d0 = vec_q[0];

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Directed bench for mux_sweep_ctrl with a behavioural mux that can be faulted.
module tb_mux_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: default HOLD_CYCLES=4
  logic       start_a, y_a, s_a, d0_a, d1_a, busy_a, done_a, err_a;
  logic [7:0] truth_a;
  logic [2:0] fei_a;
  logic [1:0] mode;

  // Instance B: HOLD_CYCLES=1
  logic       start_b, y_b, s_b, d0_b, d1_b, busy_b, done_b, err_b;
  logic [7:0] truth_b;
  logic [2:0] fei_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // mode 0: ideal mux, 1: output stuck at 0, 2: select stuck at 0
  assign y_a = (mode == 2'd0) ? (s_a ? d1_a : d0_a) :
               (mode == 2'd1) ? 1'b0 : d0_a;
  assign y_b = s_b ? d1_b : d0_b;

  mux_sweep_ctrl #(.HOLD_CYCLES(4), .CNT_W(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y(y_a),
    .s(s_a), .d0(d0_a), .d1(d1_a), .busy(busy_a), .done(done_a),
    .truth(truth_a), .err(err_a), .first_err_idx(fei_a)
  );

  mux_sweep_ctrl #(.HOLD_CYCLES(1), .CNT_W(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b),
    .s(s_b), .d0(d0_b), .d1(d1_b), .busy(busy_b), .done(done_b),
    .truth(truth_b), .err(err_b), .first_err_idx(fei_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep on instance A; restart_at > 0 re-pulses start after that edge.
  task automatic run_sweep(input string nm, input logic [7:0] et, input logic ee,
                           input logic [2:0] ef, input int restart_at);
    int n;
    int done_cnt;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check({nm, " busy@E0+1"}, int'(busy_a), 1);
    check({nm, " done@E0+1"}, int'(done_a), 0);
    check({nm, " truth_clr"}, int'(truth_a), 0);
    check({nm, " err_clr"}, int'(err_a), 0);
    check({nm, " fei_clr"}, int'(fei_a), 0);
    n = 0;
    done_cnt = 0;
    while (!done_a && n < 100) begin
      tick();
      n++;
      start_a = (restart_at > 0 && n == restart_at) ? 1'b1 : 1'b0;
      if (!done_a) begin
        check({nm, " vec"}, int'({s_a, d1_a, d0_a}), n / 4);
        check({nm, " busy"}, int'(busy_a), 1);
      end
    end
    start_a = 1'b0;
    check({nm, " done_edge"}, n, 32);
    check({nm, " busy@done"}, int'(busy_a), 0);
    check({nm, " pins@done"}, int'({s_a, d1_a, d0_a}), 0);
    check({nm, " truth"}, int'(truth_a), int'(et));
    check({nm, " err"}, int'(err_a), int'(ee));
    check({nm, " fei"}, int'(fei_a), int'(ef));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_a) done_cnt++;
      check({nm, " idle_busy"}, int'(busy_a), 0);
    end
    check({nm, " single_done"}, done_cnt, 0);
    check({nm, " truth_hold"}, int'(truth_a), int'(et));
    check({nm, " err_hold"}, int'(err_a), int'(ee));
  endtask

  typedef struct {
    string      nm;
    logic [1:0] mode;
    logic [7:0] truth;
    logic       err;
    logic [2:0] fei;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int n;
    tbl[0] = '{nm: "ideal",    mode: 2'd0, truth: 8'hCA, err: 1'b0, fei: 3'd0};
    tbl[1] = '{nm: "y_tied0",  mode: 2'd1, truth: 8'h00, err: 1'b1, fei: 3'd1};
    tbl[2] = '{nm: "sel_stk0", mode: 2'd2, truth: 8'hAA, err: 1'b1, fei: 3'd5};

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode    = 2'd0;
    repeat (3) @(negedge clk);
    check("rst busy", int'(busy_a), 0);
    check("rst done", int'(done_a), 0);
    check("rst pins", int'({s_a, d1_a, d0_a}), 0);
    check("rst truth", int'(truth_a), 0);
    check("rst err", int'(err_a), 0);
    check("rst fei", int'(fei_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven sweeps against different mux behaviours
    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      run_sweep(tbl[i].nm, tbl[i].truth, tbl[i].err, tbl[i].fei, 0);
    end

    // start re-pulsed while vector 3 is applied
    mode = 2'd0;
    run_sweep("restart", 8'hCA, 1'b0, 3'd0, 13);

    // Reset while vector 5 is applied
    mode = 2'd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (n < 21) begin
      tick();
      n++;
    end
    check("mid vec5", int'({s_a, d1_a, d0_a}), 5);
    check("mid err_before_rst", int'(err_a), 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", int'(busy_a), 0);
    check("midrst done", int'(done_a), 0);
    check("midrst pins", int'({s_a, d1_a, d0_a}), 0);
    check("midrst truth", int'(truth_a), 0);
    check("midrst err", int'(err_a), 0);
    check("midrst fei", int'(fei_a), 0);
    repeat (2) @(negedge clk);
    check("midrst no_done", int'(done_a), 0);
    rst_n = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    run_sweep("after_rst", 8'hCA, 1'b0, 3'd0, 0);

    // HOLD_CYCLES=1 with start held high: back-to-back sweeps
    start_b = 1'b1;
    tick();
    check("h1 busy@E0+1", int'(busy_b), 1);
    check("h1 vec0", int'({s_b, d1_b, d0_b}), 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("h1 vec", int'({s_b, d1_b, d0_b}), k);
      check("h1 busy", int'(busy_b), 1);
    end
    tick();
    check("h1 done@E0+8", int'(done_b), 1);
    check("h1 busy@done", int'(busy_b), 0);
    check("h1 truth", int'(truth_b), 8'hCA);
    check("h1 err", int'(err_b), 0);
    tick();
    check("h1 idle_done", int'(done_b), 0);
    check("h1 idle_busy", int'(busy_b), 0);
    check("h1 idle_truth", int'(truth_b), 8'hCA);
    tick();
    start_b = 1'b0;
    check("h1 restart busy", int'(busy_b), 1);
    check("h1 restart truth_clr", int'(truth_b), 0);
    check("h1 restart err_clr", int'(err_b), 0);
    n = 0;
    while (!done_b && n < 50) begin
      tick();
      n++;
    end
    check("h1 second_len", n, 8);
    check("h1 second_truth", int'(truth_b), 8'hCA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
